cpu_plic_prio: RTL and testbench
================================

# cpu_plic_prio

Parametrised platform-level interrupt controller for the CPU's external-interrupt context 0. It takes SOURCES interrupt lines, each independently configured for edge or level triggering with a programmable priority. It arbitrates the highest-priority enabled pending source above a threshold and drives o_interrupt toward the CPU core. Software reaches it through the single-beat memory-mapped bus, using a PLIC-compatible claim/complete register map.

## Interface
- SOURCES, 8: number of interrupt sources (1..31). They map to IDs 1..SOURCES; ID 0 means "none".
- PRIO_BITS, 3: width of each priority field and of the threshold (1..8).
- i_clock  in  1  clock; all state changes on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_interrupt  in  SOURCES  raw source lines; bit n-1 is ID n. They are already synchronous to i_clock.
- o_interrupt  out  1  external interrupt request to the CPU.
- o_claimed  out  1  high while any claimed source has not yet been completed.
- i_request  in  1  bus transaction request, held until o_ready.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  24  byte address within the block.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, registered.
- o_ready  out  1  one-cycle transaction acknowledge.

## Operation
- Register map (word addresses; all other addresses read 0 and ignore writes):
  - 0x000000+4·n: priority[n] for n = 1..SOURCES, in bits [PRIO_BITS-1:0]. Upper bits are ignored on write and read as zero. Address 0x000000 reads 0.
  - 0x001000: pending, read-only. Bit n = ID n; bit 0 is always 0.
  - 0x002000: enable. Bit n = ID n; bit 0 is forced to 0.
  - 0x003000: mode. Bit n = 1 selects level triggering, 0 selects edge triggering. Bit 0 is forced to 0.
  - 0x200000: threshold, in [PRIO_BITS-1:0].
  - 0x200004: claim on read; complete on write, with the ID in i_wdata[4:0].
- Gateway: each source keeps a 2-bit history, shifted as hist <= {hist[0], line} every cycle.
  - Edge mode: pending[n] is set when hist == 2'b01. This is independent of enable and of in-flight state.
  - Level mode: pending[n] is set when hist[0] == 1 and inflight[n] == 0. It stays set if the line drops before claim.
- Eligible source: pending & enable & (priority > threshold). Priority 0 therefore never interrupts.
- Winner: the eligible ID with the highest priority; ties go to the lowest ID.
- o_interrupt = a winner exists. This is combinational from registered state.
- Claim read: o_rdata <= winner ID, or 0 if there is none. If the winner is non-zero, pending[winner] is cleared and inflight[winner] is set. Claiming with no winner changes no state.
- Complete write: clears inflight[id] if 1 ≤ id ≤ SOURCES; any other id is ignored.
- o_claimed = |inflight.
- Simultaneous events in the same cycle:
  - Claim clears pending and a new edge arrives on the same source: the edge wins, so pending stays 1.
  - Set and clear of inflight target different IDs: both apply.
  - Complete and claim are the same transaction slot, so they cannot coincide.
- Level gateway uses registered inflight, so a source completed while its line is still high re-pends one cycle after the complete.

## Timing
- Reset values:
  - All outputs 0.
  - hist, pending, enable, mode, inflight, threshold and all priorities 0.
- A transaction is accepted on a cycle with i_request && !o_ready.
- o_ready is 1 in the following cycle, for exactly one cycle.
- Read data is valid in o_rdata while o_ready = 1 and holds until the next accepted read.
- Write effects are visible from the cycle o_ready rises.
- If the master keeps i_request high, a new transaction is accepted every second cycle.
- Edge-mode latency: line high before edge k → pending set after edge k+1 → o_interrupt high from edge k+1 (2 cycles).
- Level-mode latency: identical, 2 cycles.
- Claim arbitration uses the state sampled in the acceptance cycle.
- Reset asserted mid-transaction: o_ready is 0 next cycle, the transaction is dropped, and all state returns to reset values.

## Test plan
- Reset, then read every register: all read 0. o_interrupt = 0, o_claimed = 0, o_ready = 0.
- Source 3 in edge mode, priority 2, enabled, threshold 0. Pulse the line for 1 cycle:
  - o_interrupt rises 2 cycles later.
  - Claim reads 3; pending[3] clears; o_claimed = 1.
  - Complete with 3 drops o_claimed.
- Sources 2 and 5 both pending and enabled:
  - Priorities 4 and 6: claim returns 5.
  - Equal priorities: claim returns 2.
  - Threshold 6 with priorities 4 and 6: o_interrupt = 0 and claim returns 0.
- Source 1 in level mode, line held high:
  - Claim returns 1 and no re-pend occurs while in flight.
  - Complete with 1 → pending[1] = 1 the next cycle → o_interrupt reasserts.
- Source 4 disabled, edge pulsed:
  - pending bit 4 reads 1 and o_interrupt stays 0.
  - Enabling source 4 raises o_interrupt on the cycle the write's o_ready rises.
- Edge mode, edge arrives in the same cycle as the claim of that source: pending stays 1 after the claim, and a second claim returns the same ID.

Source files
------------

// File: rtl/cpu_plic_prio_if.sv
// Purpose: single-beat memory-mapped bus between a CPU master and cpu_plic_prio.
// Latency: o_ready/o_rdata come back one cycle after a request is accepted.
// Backpressure: master holds i_request until o_ready; at most one beat every two cycles.
// Ports: i_request/i_rw/i_address/i_wdata (master -> slave), o_rdata/o_ready (slave -> master).
interface cpu_plic_prio_if;
  logic        i_request;
  logic        i_rw;
  logic [23:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;

  modport master (
    output i_request, i_rw, i_address, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_request, i_rw, i_address, i_wdata,
    output o_rdata, o_ready
  );
endinterface

// File: rtl/cpu_plic_prio.sv
// Purpose: PLIC for external-interrupt context 0; per-source edge/level gateway, priority arbitration, claim/complete.
// Latency: source line to o_interrupt 2 cycles; bus access acknowledged 1 cycle after acceptance.
// Backpressure: none on sources; bus accepts a new beat every second cycle while i_request is held.
// Ports: i_clock, i_reset (sync, active-high), i_interrupt[SOURCES-1:0] (bit n-1 = ID n),
//        o_interrupt, o_claimed, bus (cpu_plic_prio_if.slave).
module cpu_plic_prio #(
  parameter int SOURCES   = 8,
  parameter int PRIO_BITS = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [SOURCES-1:0] i_interrupt,
  output logic               o_interrupt,
  output logic               o_claimed,
  cpu_plic_prio_if.slave     bus
);

  // Word-address decode (byte address >> 2)
  localparam logic [21:0] W_PEND  = 22'h000400;
  localparam logic [21:0] W_EN    = 22'h000800;
  localparam logic [21:0] W_MODE  = 22'h000C00;
  localparam logic [21:0] W_THR   = 22'h080000;
  localparam logic [21:0] W_CLAIM = 22'h080001;

  // Per-source state is indexed by interrupt ID so that bit n is ID n.
  logic [SOURCES:1]     r_hist0;     // most recent sample of the line
  logic [SOURCES:1]     r_hist1;     // sample before that
  logic [SOURCES:1]     r_pending;
  logic [SOURCES:1]     r_enable;
  logic [SOURCES:1]     r_mode;      // 1 = level, 0 = edge
  logic [SOURCES:1]     r_inflight;
  logic [PRIO_BITS-1:0] r_prio [1:SOURCES];
  logic [PRIO_BITS-1:0] r_threshold;
  logic                 r_ready;
  logic [31:0]          r_rdata;

  logic                 w_accept;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_claim;
  logic                 w_complete;
  logic [21:0]          w_word;
  logic [4:0]           w_cmp_id;
  logic [4:0]           w_win_id;
  logic [PRIO_BITS-1:0] w_win_prio;
  logic [SOURCES:1]     w_claim_oh;
  logic [SOURCES:1]     w_cmp_oh;
  logic [SOURCES:1]     w_set_edge;
  logic [SOURCES:1]     w_set_lvl;
  logic [SOURCES:1]     w_pending_nxt;
  logic [SOURCES:1]     w_inflight_nxt;
  logic [31:0]          w_rd_data;
  logic                 w_unused;

  assign w_accept   = bus.i_request && !r_ready;
  assign w_rd       = w_accept && !bus.i_rw;
  assign w_wr       = w_accept &&  bus.i_rw;
  assign w_word     = bus.i_address[23:2];
  assign w_claim    = w_rd && (w_word == W_CLAIM);
  assign w_complete = w_wr && (w_word == W_CLAIM);
  assign w_cmp_id   = bus.i_wdata[4:0];

  // Byte-lane bits and unused data bits carry no meaning for this block.
  assign w_unused = ^{bus.i_address[1:0], bus.i_wdata};

  // Winner: strict '>' keeps the lowest ID on ties. Eligibility needs
  // priority > threshold >= 0, so a zero best-priority means "no winner yet".
  always_comb begin
    w_win_id   = '0;
    w_win_prio = '0;
    for (int n = 1; n <= SOURCES; n++) begin
      if (r_pending[n] && r_enable[n] && (r_prio[n] > r_threshold) &&
          (r_prio[n] > w_win_prio)) begin
        w_win_id   = 5'(n);
        w_win_prio = r_prio[n];
      end
    end
  end

  always_comb begin
    w_claim_oh = '0;
    w_cmp_oh   = '0;
    for (int n = 1; n <= SOURCES; n++) begin
      w_claim_oh[n] = w_claim    && (w_win_id == 5'(n));
      w_cmp_oh[n]   = w_complete && (w_cmp_id == 5'(n));
    end
  end

  // Gateway. A new edge beats a same-cycle claim clear; the level request
  // does not, otherwise a claimed level source would re-pend immediately.
  assign w_set_edge     = ~r_mode & r_hist0 & ~r_hist1;
  assign w_set_lvl      =  r_mode & r_hist0 & ~r_inflight;
  assign w_pending_nxt  = w_set_edge | ((w_set_lvl | r_pending) & ~w_claim_oh);
  assign w_inflight_nxt = (r_inflight | w_claim_oh) & ~w_cmp_oh;

  always_comb begin
    w_rd_data = '0;
    if (w_word == W_PEND) begin
      w_rd_data = 32'({r_pending, 1'b0});
    end else if (w_word == W_EN) begin
      w_rd_data = 32'({r_enable, 1'b0});
    end else if (w_word == W_MODE) begin
      w_rd_data = 32'({r_mode, 1'b0});
    end else if (w_word == W_THR) begin
      w_rd_data = 32'(r_threshold);
    end else if (w_word == W_CLAIM) begin
      w_rd_data = 32'(w_win_id);
    end else begin
      for (int n = 1; n <= SOURCES; n++) begin
        if (w_word == 22'(n)) w_rd_data = 32'(r_prio[n]);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hist0     <= '0;
      r_hist1     <= '0;
      r_pending   <= '0;
      r_enable    <= '0;
      r_mode      <= '0;
      r_inflight  <= '0;
      r_threshold <= '0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      for (int n = 1; n <= SOURCES; n++) r_prio[n] <= '0;
    end else begin
      r_hist0    <= i_interrupt;
      r_hist1    <= r_hist0;
      r_pending  <= w_pending_nxt;
      r_inflight <= w_inflight_nxt;
      r_ready    <= w_accept;
      if (w_rd) r_rdata <= w_rd_data;
      if (w_wr) begin
        if (w_word == W_EN)   r_enable    <= bus.i_wdata[SOURCES:1];
        if (w_word == W_MODE) r_mode      <= bus.i_wdata[SOURCES:1];
        if (w_word == W_THR)  r_threshold <= bus.i_wdata[PRIO_BITS-1:0];
        for (int n = 1; n <= SOURCES; n++) begin
          if (w_word == 22'(n)) r_prio[n] <= bus.i_wdata[PRIO_BITS-1:0];
        end
      end
    end
  end

  assign o_interrupt = (w_win_id != 5'd0);
  assign o_claimed   = |r_inflight;
  assign bus.o_ready = r_ready;
  assign bus.o_rdata = r_rdata;

endmodule

// File: tb/tb_cpu_plic_prio.sv
// Purpose: self-checking bench for cpu_plic_prio; read results checked through an expected-value queue.
// Latency: inputs driven and outputs sampled on the falling edge of the clock.
// Backpressure: bus master holds i_request until o_ready, bounded by a cycle budget.
module tb_cpu_plic_prio;
  localparam int SOURCES   = 8;
  localparam int PRIO_BITS = 3;

  localparam logic [23:0] A_PEND  = 24'h001000;
  localparam logic [23:0] A_EN    = 24'h002000;
  localparam logic [23:0] A_MODE  = 24'h003000;
  localparam logic [23:0] A_THR   = 24'h200000;
  localparam logic [23:0] A_CLAIM = 24'h200004;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [SOURCES-1:0] irq_lines = '0;
  logic               irq;
  logic               claimed;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];

  cpu_plic_prio_if bus_if();

  cpu_plic_prio #(.SOURCES(SOURCES), .PRIO_BITS(PRIO_BITS)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_interrupt (irq_lines),
    .o_interrupt (irq),
    .o_claimed   (claimed),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] a_prio(input int n);
    return 24'(4 * n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic rw, input logic [23:0] addr, input logic [31:0] wdata,
                          input string tag);
    int          cyc;
    logic [31:0] expv;
    @(negedge clk);
    bus_if.i_request = 1'b1;
    bus_if.i_rw      = rw;
    bus_if.i_address = addr;
    bus_if.i_wdata   = wdata;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus_if.o_ready && cyc < 8);
    bus_if.i_request = 1'b0;
    chk({tag, "/ready"}, 32'(bus_if.o_ready), 32'd1);
    if (!rw) begin
      expv = exp_q.pop_front();
      chk(tag, bus_if.o_rdata, expv);
    end
  endtask

  task automatic rd(input logic [23:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    bus_xfer(1'b0, addr, 32'd0, tag);
  endtask

  task automatic wr(input logic [23:0] addr, input logic [31:0] data);
    bus_xfer(1'b1, addr, data, "wr");
  endtask

  task automatic pulse(input logic [SOURCES-1:0] mask);
    @(negedge clk);
    irq_lines = irq_lines | mask;
    @(negedge clk);
    irq_lines = irq_lines & ~mask;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.i_request = 1'b0;
    bus_if.i_rw      = 1'b0;
    bus_if.i_address = '0;
    bus_if.i_wdata   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst irq", 32'(irq), 0);
    chk("rst claimed", 32'(claimed), 0);
    chk("rst ready", 32'(bus_if.o_ready), 0);
    for (int n = 0; n <= SOURCES; n++) rd(a_prio(n), 0, "rst prio");
    rd(A_PEND, 0, "rst pend");
    rd(A_EN, 0, "rst en");
    rd(A_MODE, 0, "rst mode");
    rd(A_THR, 0, "rst thr");
    rd(A_CLAIM, 0, "rst claim");
    rd(24'h004000, 0, "unmapped");

    // Source 3, edge mode; upper priority bits must be dropped
    wr(a_prio(3), 32'hFFFF_FFF2);
    rd(a_prio(3), 2, "prio3 mask");
    wr(A_EN, 32'h8);
    @(negedge clk);
    irq_lines[2] = 1'b1;
    @(negedge clk);
    irq_lines[2] = 1'b0;
    chk("edge3 lat1", 32'(irq), 0);
    @(negedge clk);
    chk("edge3 lat2", 32'(irq), 1);
    rd(A_PEND, 32'h8, "pend3");
    rd(A_CLAIM, 3, "claim3");
    chk("claimed3", 32'(claimed), 1);
    rd(A_PEND, 0, "pend3 clr");
    chk("irq3 off", 32'(irq), 0);
    wr(A_CLAIM, 0);
    wr(A_CLAIM, 9);
    chk("bad cmp ignored", 32'(claimed), 1);
    wr(A_CLAIM, 3);
    chk("cmp3", 32'(claimed), 0);

    // Sources 2 and 5: priority, tie and threshold
    wr(a_prio(2), 4);
    wr(a_prio(5), 6);
    wr(A_EN, 32'h24);
    pulse(8'h12);
    rd(A_PEND, 32'h24, "pend25");
    rd(A_CLAIM, 5, "claim hi prio");
    wr(A_CLAIM, 5);
    wr(a_prio(5), 4);
    pulse(8'h10);
    rd(A_CLAIM, 2, "claim tie");
    wr(A_CLAIM, 2);
    pulse(8'h02);
    wr(a_prio(5), 6);
    wr(A_THR, 6);
    rd(A_THR, 6, "thr rb");
    chk("thr6 irq", 32'(irq), 0);
    rd(A_CLAIM, 0, "claim thr6");
    rd(A_PEND, 32'h24, "pend kept");
    wr(A_THR, 5);
    rd(A_CLAIM, 5, "claim thr5");
    wr(A_THR, 0);
    rd(A_CLAIM, 2, "claim 2 last");
    wr(A_CLAIM, 5);
    wr(A_CLAIM, 2);
    rd(A_PEND, 0, "pend25 clr");
    chk("cmp25", 32'(claimed), 0);
    wr(A_EN, 0);

    // Source 1, level mode
    wr(A_MODE, 32'h2);
    rd(A_MODE, 32'h2, "mode rb");
    wr(a_prio(1), 3);
    wr(A_EN, 32'h2);
    @(negedge clk);
    irq_lines[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("lvl irq", 32'(irq), 1);
    rd(A_CLAIM, 1, "claim lvl");
    repeat (3) @(negedge clk);
    rd(A_PEND, 0, "lvl no repend");
    chk("lvl irq off", 32'(irq), 0);
    chk("lvl claimed", 32'(claimed), 1);
    wr(A_CLAIM, 1);
    chk("lvl repend lat1", 32'(irq), 0);
    @(negedge clk);
    chk("lvl repend lat2", 32'(irq), 1);
    rd(A_PEND, 32'h2, "lvl repend");
    irq_lines[0] = 1'b0;
    rd(A_CLAIM, 1, "lvl sticky");
    wr(A_CLAIM, 1);
    repeat (2) @(negedge clk);
    rd(A_PEND, 0, "lvl idle");
    wr(A_MODE, 0);
    wr(A_EN, 0);

    // Source 4 disabled while its edge arrives
    wr(a_prio(4), 5);
    pulse(8'h08);
    rd(A_PEND, 32'h10, "pend4 dis");
    chk("dis irq", 32'(irq), 0);
    wr(A_EN, 32'h10);
    chk("en irq", 32'(irq), 1);
    rd(A_CLAIM, 4, "claim4");
    wr(A_CLAIM, 4);

    // Source 6: new edge in the claim's acceptance cycle
    wr(a_prio(6), 2);
    wr(A_EN, 32'h40);
    pulse(8'h20);
    chk("irq6", 32'(irq), 1);
    @(negedge clk);
    irq_lines[5] = 1'b1;
    rd(A_CLAIM, 6, "claim6 a");
    rd(A_PEND, 32'h40, "edge wins");
    irq_lines[5] = 1'b0;
    rd(A_CLAIM, 6, "claim6 b");
    chk("claimed6", 32'(claimed), 1);

    // Reset during a pending transaction
    @(negedge clk);
    rst = 1'b1;
    bus_if.i_request = 1'b1;
    bus_if.i_rw      = 1'b0;
    bus_if.i_address = A_CLAIM;
    @(negedge clk);
    chk("mid rst ready", 32'(bus_if.o_ready), 0);
    chk("mid rst claimed", 32'(claimed), 0);
    chk("mid rst irq", 32'(irq), 0);
    bus_if.i_request = 1'b0;
    rst = 1'b0;
    rd(A_EN, 0, "post rst en");
    rd(a_prio(6), 0, "post rst prio6");
    rd(A_PEND, 0, "post rst pend");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
